// File: rtl/hamming_secded_pipe.sv
// Two-stage pipelined Hamming SEC-DED decoder with valid/ready stream and saturating error counters.
// Optional: define HAMMING_SYND_OUT_EN to expose the registered syndrome {pe, s} on out_synd.
module hamming_secded_pipe #(
    parameter int DATA_W = 64,
    parameter int P_W    = 7,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W+P_W:0]      in_cw,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_sec,
    output logic                     out_ded,
`ifdef HAMMING_SYND_OUT_EN
    output logic [P_W:0]             out_synd,
`endif
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         corr_cnt,
    output logic [CNT_W-1:0]         uncorr_cnt
);
    localparam int N = DATA_W + P_W + 1;

    generate
        if ((2 ** P_W) < N) begin : g_chk_pw
            $error("hamming_secded_pipe: 2**P_W must be >= DATA_W+P_W+1");
        end
        if (P_W > 0 && (2 ** (P_W - 1)) >= N) begin : g_chk_pw_max
            $error("hamming_secded_pipe: P_W too large, parity positions exceed codeword");
        end
    endgenerate

    // Position of data bit idx inside the codeword: skip index 0 and every power of two.
    function automatic int pos_of(input int idx);
        int c;
        c = 0;
        for (int p = 1; p < N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (c == idx) return p;
                c++;
            end
        end
        return 0;
    endfunction

    logic                w_s1_en;
    logic                w_s2_en;
    logic                w_xfer;
    logic [P_W-1:0]      w_s;
    logic                w_pe;
    logic [DATA_W-1:0]   w_raw;
    logic [DATA_W-1:0]   w_flip;
    logic                w_sec;
    logic                w_ded;
    logic [DATA_W-1:0]   w_data;

    logic                r_s1_v;
    logic [DATA_W-1:0]   r_s1_raw;
    logic [P_W-1:0]      r_s1_s;
    logic                r_s1_pe;
    logic                r_s2_v;
    logic [DATA_W-1:0]   r_data;
    logic                r_sec;
    logic                r_ded;
    logic [CNT_W-1:0]    r_corr;
    logic [CNT_W-1:0]    r_uncorr;

    always_comb begin
        w_s = '0;
        for (int i = 1; i < N; i++) begin
            if (in_cw[i]) w_s = w_s ^ P_W'(i);
        end
    end
    assign w_pe = ^in_cw;

    // S1 keeps only the payload bits; parity positions are fully summarised by s and pe.
    generate
        for (genvar g = 0; g < DATA_W; g++) begin : g_map
            localparam int POS = pos_of(g);
            assign w_raw[g]  = in_cw[POS];
            assign w_flip[g] = (r_s1_s == P_W'(POS));
        end
    endgenerate

    assign w_sec  = r_s1_pe && (int'(r_s1_s) < N);
    assign w_ded  = r_s1_pe ? !w_sec : (r_s1_s != '0);
    assign w_data = w_sec ? (r_s1_raw ^ w_flip) : r_s1_raw;

    assign w_s2_en  = !r_s2_v || out_ready;
    assign w_s1_en  = !r_s1_v || w_s2_en;
    assign w_xfer   = r_s2_v && out_ready;
    assign in_ready = !rst && w_s1_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v   <= 1'b0;
            r_s1_raw <= '0;
            r_s1_s   <= '0;
            r_s1_pe  <= 1'b0;
            r_s2_v   <= 1'b0;
            r_data   <= '0;
            r_sec    <= 1'b0;
            r_ded    <= 1'b0;
        end else begin
            if (w_s1_en) begin
                r_s1_v <= in_valid;
                if (in_valid) begin
                    r_s1_raw <= w_raw;
                    r_s1_s   <= w_s;
                    r_s1_pe  <= w_pe;
                end
            end
            // Output registers only move when a new beat replaces the old one, so they hold under stall.
            if (w_s2_en) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_data <= w_data;
                    r_sec  <= w_sec;
                    r_ded  <= w_ded;
                end
            end
        end
    end

`ifdef HAMMING_SYND_OUT_EN
    logic [P_W:0] r_synd;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_synd <= '0;
        end else if (w_s2_en && r_s1_v) begin
            r_synd <= {r_s1_pe, r_s1_s};
        end
    end
    assign out_synd = r_synd;
`endif

    // Count on transfer out; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_corr   <= '0;
            r_uncorr <= '0;
        end else if (w_xfer) begin
            if (r_sec && r_corr != '1)   r_corr   <= r_corr + 1'b1;
            if (r_ded && r_uncorr != '1) r_uncorr <= r_uncorr + 1'b1;
        end
    end

    assign out_valid  = r_s2_v;
    assign out_data   = r_data;
    assign out_sec    = r_sec;
    assign out_ded    = r_ded;
    assign corr_cnt   = r_corr;
    assign uncorr_cnt = r_uncorr;
endmodule
